// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: instruction-fetch front end.
// Issues sequential fetches over a req/gnt/rvalid memory port with several
// requests in flight, buffers the returned words (tagged with their PC) in a
// small circular queue toward decode, and handles redirects: the queue is
// flushed, in-flight responses are dropped through a discard counter, and a
// misaligned target parks the unit in FAULT behind a single fault entry.
//
// Handshakes: ImemReq/ImemGnt transfer a request on a cycle where both are 1.
// ImemRvalid returns one response per grant, in order. InstrValid/InstrReady
// transfer the head entry on a cycle where both are 1. A valid output never
// depends combinationally on the matching ready input.
module rv_fetch_queue #(
    parameter int                  PC_WIDTH        = 32,
    parameter int                  INSTR_WIDTH     = 32,
    parameter int                  DEPTH           = 4,
    parameter int                  MAX_OUTSTANDING = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                   clk,
    input  logic                   Reset,
    output logic                   ImemReq,
    output logic [PC_WIDTH-1:0]    ImemAddr,
    input  logic                   ImemGnt,
    input  logic                   ImemRvalid,
    input  logic [INSTR_WIDTH-1:0] ImemRdata,
    input  logic                   RedirectValid,
    input  logic [PC_WIDTH-1:0]    RedirectPc,
    output logic                   InstrValid,
    input  logic                   InstrReady,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    InstrPc,
    output logic                   InstrFault,
    output logic                   fsm_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT      = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_SLOT    = PW'(DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    resp_pc;
    logic [CW-1:0]          count;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          outstanding_next;
    logic [CW:0]            credit_used;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [INSTR_WIDTH-1:0] data_mem  [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [DEPTH-1:0]       fault_mem;

    logic grant;
    logic pop;
    logic keep;
    logic drop;
    logic redirect_misaligned;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // Next-state logic: a redirect picks RUN or FAULT from target alignment.
    always_comb begin
        state_next = state;
        if (RedirectValid) begin
            state_next = redirect_misaligned ? FAULT : RUN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Request credit, handshake qualifiers and head outputs.
    always_comb begin
        redirect_misaligned = |RedirectPc[1:0];
        // Entries queued plus responses still to be kept must fit the queue.
        credit_used = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};
        ImemReq     = !Reset && (state == RUN) && (credit_used < DEPTH_CREDIT)
                      && (outstanding < MAX_OUT);
        ImemAddr    = fetch_pc;
        grant       = ImemReq && ImemGnt;
        drop        = ImemRvalid && (discard != '0);
        keep        = ImemRvalid && (discard == '0) && (state == RUN) && !RedirectValid;
        InstrValid  = (count != '0);
        pop         = InstrValid && InstrReady && !RedirectValid;
        outstanding_next = outstanding + CW'(grant) - CW'(ImemRvalid);
        Instr       = InstrValid ? data_mem[head] : '0;
        InstrPc     = InstrValid ? pc_mem[head]   : '0;
        InstrFault  = InstrValid && fault_mem[head];
        fsm_state   = (state == FAULT);
    end

    // Fetch/response PCs, counters and queue pointers; redirect wins over all.
    always_ff @(posedge clk) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (RedirectValid) begin
                // Every request still unanswered after this edge is stale.
                discard  <= outstanding_next;
                fetch_pc <= RedirectPc;
                resp_pc  <= RedirectPc;
                head     <= '0;
                if (redirect_misaligned) begin
                    count <= CW'(1);
                    tail  <= ptr_inc('0);
                end else begin
                    count <= '0;
                    tail  <= '0;
                end
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + PC_WIDTH'(4);
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
                if (keep) begin
                    resp_pc <= resp_pc + PC_WIDTH'(4);
                    tail    <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    // Queue storage: kept responses, or the single fault entry at slot 0.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (RedirectValid && redirect_misaligned) begin
                data_mem[0]  <= '0;
                pc_mem[0]    <= RedirectPc;
                fault_mem[0] <= 1'b1;
            end else if (keep) begin
                data_mem[tail]  <= ImemRdata;
                pc_mem[tail]    <= resp_pc;
                fault_mem[tail] <= 1'b0;
            end
        end
    end

    // Invariants: the credit rule prevents overflow; discards never exceed in-flight.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            assert (!(keep && !pop && (count == DEPTH_COUNT)));
            assert (discard <= outstanding);
            assert (outstanding <= MAX_OUT);
        end
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: directed bench for rv_fetch_queue with an in-order
// memory responder and a scoreboard of expected {fault, pc, instr} entries.
module tb_rv_fetch_queue;

  logic        clk;
  logic        Reset;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic        InstrFault;
  logic        fsm_state;

  rv_fetch_queue #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .Reset(Reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
    .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPc(InstrPc), .InstrFault(InstrFault),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;

  // memory responder state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int lat_min = 1;
  int lat_max = 1;
  int gnt_pct = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back({1'b0, a, mem_word(a)});
    end
  endtask

  // One-cycle redirect pulse; returns at the following negedge.
  task automatic do_redirect(input logic [31:0] pc);
    RedirectValid = 1'b1;
    RedirectPc    = pc;
    exp_q.delete();
    if (pc[1:0] == 2'b00) push_stream(pc, 1024);
    else exp_q.push_back({1'b1, pc, 32'h0});
    @(negedge clk);
    RedirectValid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && !InstrValid; i++) @(negedge clk);
    check(tag, 65'(InstrValid), 65'(1));
  endtask

  // driver: memory responder (grants, in-order responses after a latency)
  initial begin
    pend_t p;
    int    cyc;
    cyc = 0;
    ImemGnt = 1'b0;
    ImemRvalid = 1'b0;
    ImemRdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (Reset) begin
        pend_q.delete();
        ImemRvalid = 1'b0;
        ImemRdata  = '0;
        ImemGnt    = 1'b0;
      end else begin
        ImemRvalid = 1'b0;
        ImemRdata  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          p = pend_q.pop_front();
          ImemRvalid = 1'b1;
          ImemRdata  = mem_word(p.addr);
        end
        ImemGnt = ($urandom_range(99) < gnt_pct);
        if (ImemReq && ImemGnt) begin
          p.addr = ImemAddr;
          p.due  = cyc + $urandom_range(lat_max, lat_min);
          pend_q.push_back(p);
        end
      end
      cyc++;
    end
  end

  // scoreboard: compare every accepted head entry against exp_q
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!Reset && !RedirectValid && InstrValid && InstrReady) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", 65'(exp_q.size()), 65'(1));
        end else begin
          e = exp_q.pop_front();
          check("instr", {InstrFault, InstrPc, Instr}, e);
        end
      end
    end
  end

  // directed steps
  initial begin
    int pops0;
    Reset = 1'b1;
    RedirectValid = 1'b0;
    RedirectPc = '0;
    InstrReady = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 65'(ImemReq), 65'(0));
    check("rst_addr", 65'(ImemAddr), 65'(0));
    check("rst_valid", 65'(InstrValid), 65'(0));
    check("rst_instr", 65'(Instr), 65'(0));
    check("rst_pc", 65'(InstrPc), 65'(0));
    check("rst_fault", 65'(InstrFault), 65'(0));
    check("rst_state", 65'(fsm_state), 65'(0));

    // streaming from reset: 2-cycle startup then one per cycle
    Reset = 1'b0;
    push_stream(32'h0, 1024);
    @(negedge clk);
    check("startup_c1_empty", 65'(InstrValid), 65'(0));
    @(negedge clk);
    check("startup_c2_valid", 65'(InstrValid), 65'(1));
    check("startup_pc", 65'(InstrPc), 65'(0));
    check("startup_data", 65'(Instr), 65'(mem_word(32'h0)));
    pops0 = n_pop;
    repeat (10) @(negedge clk);
    check("throughput", 65'(n_pop - pops0), 65'(10));

    // backpressure fills the queue and stops requests
    InstrReady = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_valid", 65'(InstrValid), 65'(1));
    check("stall_req_low", 65'(ImemReq), 65'(0));
    InstrReady = 1'b1;
    pops0 = n_pop;
    repeat (4) @(negedge clk);
    check("drain_4", 65'(n_pop - pops0), 65'(4));

    // redirect with two slow responses in flight
    lat_min = 3;
    lat_max = 3;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20 && pend_q.size() != 2; i++) @(negedge clk);
    check("two_in_flight", 65'(pend_q.size()), 65'(2));
    do_redirect(32'h100);
    check("redir100_flush", 65'(InstrValid), 65'(0));
    wait_valid(40, "redir100_wait");
    check("redir100_pc", 65'(InstrPc), 65'(32'h100));
    check("redir100_data", 65'(Instr), 65'(mem_word(32'h100)));

    // redirect coinciding with rvalid, grant and pop
    lat_min = 1;
    lat_max = 1;
    repeat (10) @(negedge clk);
    check("pre_busy", 65'({InstrValid, ImemReq}), 65'(2'b11));
    do_redirect(32'h300);
    check("redir300_flush", 65'(InstrValid), 65'(0));
    wait_valid(20, "redir300_wait");
    check("redir300_pc", 65'(InstrPc), 65'(32'h300));

    // misaligned target: single fault entry, fetch halted
    repeat (5) @(negedge clk);
    do_redirect(32'h102);
    check("fault_valid", 65'(InstrValid), 65'(1));
    check("fault_entry", {InstrFault, InstrPc, Instr}, {1'b1, 32'h102, 32'h0});
    check("fault_req_low", 65'(ImemReq), 65'(0));
    check("fault_state", 65'(fsm_state), 65'(1));
    repeat (8) @(negedge clk);
    check("fault_empty", 65'(InstrValid), 65'(0));
    check("fault_req_stays_low", 65'(ImemReq), 65'(0));
    do_redirect(32'h200);
    check("resume_state", 65'(fsm_state), 65'(0));
    wait_valid(20, "resume_wait");
    check("resume_pc", 65'(InstrPc), 65'(32'h200));
    check("resume_fault", 65'(InstrFault), 65'(0));

    // random grants, latencies and backpressure with one redirect midway
    gnt_pct = 60;
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 300; i++) begin
      InstrReady = 1'($urandom_range(1));
      if (i == 150) do_redirect(32'h1000);
      else @(negedge clk);
    end
    InstrReady = 1'b1;
    gnt_pct = 100;
    lat_min = 1;
    lat_max = 1;
    repeat (10) @(negedge clk);

    // reset in mid-stream with a partially full queue
    InstrReady = 1'b0;
    repeat (3) @(negedge clk);
    check("partial_valid", 65'(InstrValid), 65'(1));
    Reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", 65'(InstrValid), 65'(0));
    check("midrst_addr", 65'(ImemAddr), 65'(0));
    check("midrst_req", 65'(ImemReq), 65'(0));
    check("midrst_state", 65'(fsm_state), 65'(0));
    Reset = 1'b0;
    InstrReady = 1'b1;
    push_stream(32'h0, 1024);
    @(negedge clk);
    check("restart_c1_empty", 65'(InstrValid), 65'(0));
    @(negedge clk);
    check("restart_c2_valid", 65'(InstrValid), 65'(1));
    check("restart_pc", 65'(InstrPc), 65'(0));
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the RISC-V core; successor to the bare PC register plus synchronous program-memory read.
- Generates sequential fetch addresses over a req/gnt/rvalid instruction-memory interface with multiple requests outstanding.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry queue toward decode (valid/ready).
- Handles branch/jump redirects (flush plus discard of in-flight responses) and misaligned redirect targets (fault entry plus halt).

Parameters:
- PC_WIDTH, 32, width of all PCs and memory addresses.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, instruction queue entries (≥2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests (1..DEPTH).
- RESET_PC, 0, first fetch address after reset; must be 4-aligned.

Ports:
- clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  PC_WIDTH  fetch address, 4-aligned.
- ImemGnt  in  1  request accepted this cycle.
- ImemRvalid  in  1  response valid; responses are in order, one per grant, at least 1 cycle after the grant.
- ImemRdata  in  INSTR_WIDTH  response data.
- RedirectValid  in  1  redirect fetch to RedirectPc.
- RedirectPc  in  PC_WIDTH  new fetch PC.
- InstrValid  out  1  queue head valid.
- InstrReady  in  1  decode accepts head.
- Instr  out  INSTR_WIDTH  head instruction.
- InstrPc  out  PC_WIDTH  head PC.
- InstrFault  out  1  head is a misaligned-fetch fault entry.

Behaviour:
- Internal state:
  - FetchPc: next request address.
  - RespPc: PC of the next kept response.
  - Count: queue occupancy.
  - Outstanding: granted requests without a response.
  - Discard: responses still to drop.
  - FSM: RUN or FAULT.
  - Counters are $clog2(DEPTH+1) bits wide.
- Reset:
  - FetchPc=RespPc=RESET_PC; Count=Outstanding=Discard=0; state RUN.
  - All outputs 0, except ImemAddr=RESET_PC.
  - Reset overrides everything, including in mid-transaction. After reset the bench must not drive responses for pre-reset grants.
- Request issue (combinational):
  - ImemReq = (state==RUN) && (Count+Outstanding-Discard < DEPTH) && (Outstanding < MAX_OUTSTANDING).
  - ImemAddr = FetchPc.
  - ImemReq is not gated by RedirectValid.
  - On ImemReq&&ImemGnt: FetchPc += 4 (wraps modulo 2^PC_WIDTH); Outstanding++.
- Response:
  - On ImemRvalid: Outstanding--.
  - If Discard>0, drop the data and decrement Discard.
  - Otherwise, in RUN, push {ImemRdata, RespPc, fault=0} and do RespPc += 4.
  - The credit rule guarantees a push never finds the queue full. An overflow is an assertion failure.
- Output:
  - InstrValid = Count>0; head fields come from the queue head.
  - Pop on InstrValid&&InstrReady.
  - Push and pop in the same cycle are legal: Count is unchanged.
  - Latency: a response in cycle N is visible at the head in cycle N+1 if the queue was empty.
- Redirect (RedirectValid=1 in cycle N), effective at the edge ending cycle N; it takes precedence over pop, push and fault state:
  - Queue flushed (Count=0); any pop in cycle N is ignored. Any response in cycle N is dropped.
  - Discard_next = Outstanding_next, where Outstanding_next already accounts for cycle-N grants and responses.
  - Aligned RedirectPc (bits[1:0]==0): FetchPc=RespPc=RedirectPc; state RUN.
  - Misaligned RedirectPc: state FAULT; the queue is loaded with exactly one entry {Instr=0, InstrPc=RedirectPc, InstrFault=1}; FetchPc=RedirectPc.
- FAULT state:
  - ImemReq=0; in-flight responses are drained via Discard.
  - The fault entry pops normally; the queue then stays empty.
  - Exit only by a new redirect or Reset.
- Outstanding never exceeds MAX_OUTSTANDING. Discard ≤ Outstanding at all times.

Test Plan:
- Reset, ImemGnt=1, 1-cycle rvalid, InstrReady=1 → InstrPc sequence 0,4,8,C…, one instruction per cycle after a 2-cycle startup; data matches memory.
- InstrReady=0 for 20 cycles → Count reaches 4; ImemReq drops once Count+Outstanding=4. Release → 4 queued instructions, in order, no loss or duplication.
- 3-cycle rvalid latency, MAX_OUTSTANDING=2, redirect to 0x100 while 2 requests are in flight → both late responses dropped; next InstrPc=0x100 with correct data.
- Redirect in the same cycle as ImemRvalid, a grant and a pop → queue empty next cycle; Discard=Outstanding; the first kept instruction is at the redirect target.
- Redirect to 0x102 → one entry {InstrFault=1, InstrPc=0x102, Instr=0}, ImemReq stays 0. Then redirect to 0x200 → fetching resumes at 0x200 with InstrFault=0.
- Reset asserted mid-stream with the queue partially full → next cycle InstrValid=0, ImemAddr=RESET_PC, all counters 0.
